// File: rtl/cfg_descriptor_tx.sv
// Configuration read-out: streams the elaborated core configuration
// as an 8-word descriptor closed by a running-XOR checksum word.
package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
    int unsigned VLEN;
    int unsigned PLEN;
    int unsigned GPLEN;
    int unsigned NrCommitPorts;
    int unsigned NrIssuePorts;
    int unsigned NrWbPorts;
    int unsigned NrRgprPorts;
    int unsigned NR_SB_ENTRIES;
    int unsigned FLen;
    int unsigned ICACHE_SET_ASSOC;
    int unsigned ICACHE_INDEX_WIDTH;
    int unsigned DCACHE_SET_ASSOC;
    int unsigned DCACHE_INDEX_WIDTH;
    int unsigned ICACHE_LINE_WIDTH;
    int unsigned DCACHE_LINE_WIDTH;
    int unsigned InstrTlbEntries;
    int unsigned DataTlbEntries;
    int unsigned NrPMPEntries;
    int unsigned RASDepth;
    bit RVA;
    bit RVB;
    bit RVC;
    bit RVD;
    bit RVF;
    bit RVH;
    bit RVV;
    bit RVS;
    bit RVU;
    bit RVZCB;
    bit RVZCMP;
    bit RVZiCond;
    bit RVZicntr;
    bit RVZihpm;
    bit XF16;
    bit XF16ALT;
    bit XF8;
    bit XFVec;
    bit CvxifEn;
    bit DebugEn;
    bit MmuPresent;
    bit SuperscalarEn;
    bit FpPresent;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module cfg_descriptor_tx
  import config_pkg::*;
#(
  parameter cva6_cfg_t  CVA6Cfg = cva6_cfg_empty,
  parameter logic [7:0] Version = 8'h01
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [2:0]  idx_o,
  output logic        last_o,
  output logic        done_o
);

  localparam logic [31:0] W0 = {16'hCFA6, Version, 8'd8};
  localparam logic [31:0] W1 = {
    8'(CVA6Cfg.XLEN), 8'(CVA6Cfg.VLEN),
    8'(CVA6Cfg.PLEN), 8'(CVA6Cfg.GPLEN)};
  localparam logic [31:0] W2 = {
    9'd0,
    CVA6Cfg.FpPresent, CVA6Cfg.SuperscalarEn,
    CVA6Cfg.MmuPresent, CVA6Cfg.DebugEn,
    CVA6Cfg.CvxifEn, CVA6Cfg.XFVec,
    CVA6Cfg.XF8, CVA6Cfg.XF16ALT,
    CVA6Cfg.XF16, CVA6Cfg.RVZihpm,
    CVA6Cfg.RVZicntr, CVA6Cfg.RVZiCond,
    CVA6Cfg.RVZCMP, CVA6Cfg.RVZCB,
    CVA6Cfg.RVU, CVA6Cfg.RVS,
    CVA6Cfg.RVV, CVA6Cfg.RVH,
    CVA6Cfg.RVF, CVA6Cfg.RVD,
    CVA6Cfg.RVC, CVA6Cfg.RVB,
    CVA6Cfg.RVA};
  localparam logic [31:0] W3 = {
    4'(CVA6Cfg.NrCommitPorts), 4'(CVA6Cfg.NrIssuePorts),
    4'(CVA6Cfg.NrWbPorts), 4'(CVA6Cfg.NrRgprPorts),
    8'(CVA6Cfg.NR_SB_ENTRIES), 8'(CVA6Cfg.FLen)};
  localparam logic [31:0] W4 = {
    8'(CVA6Cfg.ICACHE_SET_ASSOC), 8'(CVA6Cfg.ICACHE_INDEX_WIDTH),
    8'(CVA6Cfg.DCACHE_SET_ASSOC), 8'(CVA6Cfg.DCACHE_INDEX_WIDTH)};
  localparam logic [31:0] W5 = {
    16'(CVA6Cfg.ICACHE_LINE_WIDTH), 16'(CVA6Cfg.DCACHE_LINE_WIDTH)};
  localparam logic [31:0] W6 = {
    8'(CVA6Cfg.InstrTlbEntries), 8'(CVA6Cfg.DataTlbEntries),
    8'(CVA6Cfg.NrPMPEntries), 8'(CVA6Cfg.RASDepth)};

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_e;

  state_e      state_q;
  logic        valid_q;
  logic        done_q;
  logic [2:0]  idx_q;
  logic [31:0] acc_q;
  logic [31:0] word;

  // Select the word at the current index; word 7 is the live checksum.
  always_comb begin
    word = 32'h0;
    case (idx_q)
      3'd0:    word = W0;
      3'd1:    word = W1;
      3'd2:    word = W2;
      3'd3:    word = W3;
      3'd4:    word = W4;
      3'd5:    word = W5;
      3'd6:    word = W6;
      default: word = acc_q;
    endcase
  end

  // Descriptor FSM: flush overrides everything but reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= 3'd0;
      acc_q   <= 32'h0;
    end else if (flush_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= 3'd0;
      acc_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          idx_q  <= 3'd0;
          acc_q  <= 32'h0;
          if (req_i) begin
            state_q <= SEND;
            valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (ready_i) begin
            if (idx_q == 3'd7) begin
              state_q <= FIN;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              acc_q   <= 32'h0;
            end else begin
              acc_q <= acc_q ^ word;
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          idx_q   <= 3'd0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          idx_q   <= 3'd0;
          acc_q   <= 32'h0;
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  assign busy_o  = valid_q;
  assign done_o  = done_q;
  assign idx_o   = idx_q;
  assign last_o  = valid_q & (idx_q == 3'd7);
  assign data_o  = valid_q ? word : 32'h0;

endmodule

// File: tb/tb_cfg_descriptor_tx.sv
// Bench for cfg_descriptor_tx: vector table, directed corner
// sequences and random traffic against a word-position model.
module tb_cfg_descriptor_tx;
  import config_pkg::*;

  localparam logic [7:0] VER = 8'h01;
  localparam cva6_cfg_t CFG = '{
    XLEN: 64, VLEN: 128, PLEN: 56, GPLEN: 41,
    NrCommitPorts: 2, NrIssuePorts: 2,
    NrWbPorts: 4, NrRgprPorts: 4,
    NR_SB_ENTRIES: 8, FLen: 64,
    ICACHE_SET_ASSOC: 4, ICACHE_INDEX_WIDTH: 12,
    DCACHE_SET_ASSOC: 8, DCACHE_INDEX_WIDTH: 12,
    ICACHE_LINE_WIDTH: 128, DCACHE_LINE_WIDTH: 256,
    InstrTlbEntries: 16, DataTlbEntries: 32,
    NrPMPEntries: 8, RASDepth: 2,
    RVA: 1'b1, RVB: 1'b1, RVC: 1'b1, RVD: 1'b1, RVF: 1'b1,
    RVS: 1'b1, RVU: 1'b1, RVZCB: 1'b1, RVZiCond: 1'b1,
    RVZicntr: 1'b1, RVZihpm: 1'b1, CvxifEn: 1'b1,
    DebugEn: 1'b1, MmuPresent: 1'b1, SuperscalarEn: 1'b1,
    FpPresent: 1'b1,
    default: '0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        flush = 1'b0;
  logic        ready = 1'b0;
  logic        busy;
  logic [31:0] data;
  logic        valid;
  logic [2:0]  idx;
  logic        last;
  logic        done;

  cfg_descriptor_tx #(.CVA6Cfg(CFG), .Version(VER)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .flush_i(flush),
    .busy_o(busy), .data_o(data), .valid_o(valid), .ready_i(ready),
    .idx_o(idx), .last_o(last), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit req, flush, ready;
    bit ev, eb, ed, el;
    logic [2:0] eidx;
    logic [31:0] edata;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          pos = -1;
  int          hs_cnt = 0;
  logic [31:0] mw [8];
  logic [31:0] got [8];
  vec_t        tbl [10];

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected words straight from the field map, by plain arithmetic.
  task automatic build_model();
    bit fl [23];
    fl = '{CFG.RVA, CFG.RVB, CFG.RVC, CFG.RVD, CFG.RVF, CFG.RVH,
           CFG.RVV, CFG.RVS, CFG.RVU, CFG.RVZCB, CFG.RVZCMP,
           CFG.RVZiCond, CFG.RVZicntr, CFG.RVZihpm, CFG.XF16,
           CFG.XF16ALT, CFG.XF8, CFG.XFVec, CFG.CvxifEn,
           CFG.DebugEn, CFG.MmuPresent, CFG.SuperscalarEn,
           CFG.FpPresent};
    mw[0] = 32'hCFA6_0000 + 32'(VER) * 32'd256 + 32'd8;
    mw[1] = (CFG.XLEN % 256) * 32'h100_0000
          + (CFG.VLEN % 256) * 32'h1_0000
          + (CFG.PLEN % 256) * 32'h100
          + (CFG.GPLEN % 256);
    mw[2] = 32'd0;
    for (int k = 0; k < 23; k++)
      if (fl[k]) mw[2] = mw[2] + (32'd1 << k);
    mw[3] = (CFG.NrCommitPorts % 16) * 32'h1000_0000
          + (CFG.NrIssuePorts % 16) * 32'h100_0000
          + (CFG.NrWbPorts % 16) * 32'h10_0000
          + (CFG.NrRgprPorts % 16) * 32'h1_0000
          + (CFG.NR_SB_ENTRIES % 256) * 32'h100
          + (CFG.FLen % 256);
    mw[4] = (CFG.ICACHE_SET_ASSOC % 256) * 32'h100_0000
          + (CFG.ICACHE_INDEX_WIDTH % 256) * 32'h1_0000
          + (CFG.DCACHE_SET_ASSOC % 256) * 32'h100
          + (CFG.DCACHE_INDEX_WIDTH % 256);
    mw[5] = (CFG.ICACHE_LINE_WIDTH % 65536) * 32'h1_0000
          + (CFG.DCACHE_LINE_WIDTH % 65536);
    mw[6] = (CFG.InstrTlbEntries % 256) * 32'h100_0000
          + (CFG.DataTlbEntries % 256) * 32'h1_0000
          + (CFG.NrPMPEntries % 256) * 32'h100
          + (CFG.RASDepth % 256);
    mw[7] = 32'd0;
    for (int k = 0; k < 7; k++) mw[7] = mw[7] ^ mw[k];
  endtask

  // pos: -1 idle, 0..7 word on the bus, 8 the done cycle.
  task automatic model_edge();
    if (flush) pos = -1;
    else if (pos < 0) pos = req ? 0 : -1;
    else if (pos == 8) pos = -1;
    else if (ready) pos = pos + 1;
  endtask

  task automatic check_all(string tag);
    bit v;
    v = (pos >= 0) && (pos <= 7);
    cmp({tag, ".valid"}, 32'(valid), 32'(v));
    cmp({tag, ".busy"}, 32'(busy), 32'(v));
    cmp({tag, ".done"}, 32'(done), 32'(pos == 8));
    cmp({tag, ".last"}, 32'(last), 32'(pos == 7));
    cmp({tag, ".data"}, data, v ? mw[pos] : 32'h0);
    if (v) cmp({tag, ".idx"}, 32'(idx), 32'(pos));
  endtask

  task automatic note_hs();
    if (valid && ready && !flush) begin
      hs_cnt++;
      got[idx] = data;
    end
  endtask

  task automatic step(string tag, bit r, bit f, bit rd);
    req = r;
    flush = f;
    ready = rd;
    note_hs();
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    build_model();
    for (int k = 0; k < 8; k++) begin
      tbl[k] = '{req: (k == 0), flush: 1'b0, ready: 1'b1,
                 ev: 1'b1, eb: 1'b1, ed: 1'b0, el: (k == 7),
                 eidx: 3'(k), edata: mw[k]};
    end
    tbl[8] = '{req: 1'b0, flush: 1'b0, ready: 1'b1,
               ev: 1'b0, eb: 1'b0, ed: 1'b1, el: 1'b0,
               eidx: 3'd0, edata: 32'h0};
    tbl[9] = '{req: 1'b0, flush: 1'b0, ready: 1'b1,
               ev: 1'b0, eb: 1'b0, ed: 1'b0, el: 1'b0,
               eidx: 3'd0, edata: 32'h0};

    repeat (2) @(negedge clk);
    cmp("rst.valid", 32'(valid), 32'd0);
    cmp("rst.busy", 32'(busy), 32'd0);
    cmp("rst.done", 32'(done), 32'd0);
    cmp("rst.last", 32'(last), 32'd0);
    cmp("rst.idx", 32'(idx), 32'd0);
    cmp("rst.data", data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back descriptor from the vector table.
    hs_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req;
      flush = tbl[i].flush;
      ready = tbl[i].ready;
      note_hs();
      @(posedge clk);
      model_edge();
      #1;
      cmp("tbl.valid", 32'(valid), 32'(tbl[i].ev));
      cmp("tbl.busy", 32'(busy), 32'(tbl[i].eb));
      cmp("tbl.done", 32'(done), 32'(tbl[i].ed));
      cmp("tbl.last", 32'(last), 32'(tbl[i].el));
      cmp("tbl.data", data, tbl[i].edata);
      if (tbl[i].ev) cmp("tbl.idx", 32'(idx), 32'(tbl[i].eidx));
      @(negedge clk);
    end
    cmp("s1.hs", 32'(hs_cnt), 32'd8);
    cmp("s1.w0", got[0], 32'hCFA60108);
    cmp("s1.w7", got[7], mw[7]);
    cmp("cfg.w1", got[1], 32'h40803829);
    cmp("cfg.w3commit", 32'(got[3][31:24]), 32'h22);
    cmp("cfg.w3wb", 32'(got[3][23:20]), 32'd4);
    cmp("cfg.w3rgpr", 32'(got[3][19:16]), 32'd4);
    cmp("cfg.w2ss", 32'(got[2][21]), 32'd1);

    // Stalling sink: ready toggles every cycle.
    hs_cnt = 0;
    got[7] = 32'h0;
    step("s2", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      step("s2", 1'b0, 1'b0, (i % 2) == 0);
    cmp("s2.hs", 32'(hs_cnt), 32'd8);
    cmp("s2.w7", got[7], mw[7]);

    // Flush on the W3 handshake, then a clean restart.
    step("s3", 1'b1, 1'b0, 1'b1);
    repeat (3) step("s3", 1'b0, 1'b0, 1'b1);
    cmp("s3.at_w3", 32'(idx), 32'd3);
    step("s3f", 1'b0, 1'b1, 1'b1);
    cmp("s3f.valid", 32'(valid), 32'd0);
    cmp("s3f.busy", 32'(busy), 32'd0);
    step("s3f", 1'b0, 1'b0, 1'b1);
    cmp("s3f.done", 32'(done), 32'd0);
    hs_cnt = 0;
    got[7] = 32'h0;
    step("s3r", 1'b1, 1'b0, 1'b1);
    repeat (9) step("s3r", 1'b0, 1'b0, 1'b1);
    cmp("s3r.hs", 32'(hs_cnt), 32'd8);
    cmp("s3r.w7", got[7], mw[7]);

    // Requests during W2 and during FIN are dropped.
    hs_cnt = 0;
    step("s4", 1'b1, 1'b0, 1'b1);
    repeat (2) step("s4", 1'b0, 1'b0, 1'b1);
    step("s4req", 1'b1, 1'b0, 1'b1);
    repeat (5) step("s4", 1'b0, 1'b0, 1'b1);
    cmp("s4.done", 32'(done), 32'd1);
    step("s4fin", 1'b1, 1'b0, 1'b1);
    repeat (4) step("s4", 1'b0, 1'b0, 1'b1);
    cmp("s4.hs", 32'(hs_cnt), 32'd8);
    cmp("s4.busy", 32'(busy), 32'd0);

    // Asynchronous reset while W5 is presented.
    step("s5", 1'b1, 1'b0, 1'b1);
    repeat (5) step("s5", 1'b0, 1'b0, 1'b1);
    cmp("s5.at_w5", 32'(idx), 32'd5);
    #2;
    rst_n = 1'b0;
    pos = -1;
    #1;
    cmp("s5.valid", 32'(valid), 32'd0);
    cmp("s5.busy", 32'(busy), 32'd0);
    cmp("s5.idx", 32'(idx), 32'd0);
    cmp("s5.data", data, 32'h0);
    cmp("s5.last", 32'(last), 32'd0);
    cmp("s5.done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hs_cnt = 0;
    repeat (4) step("s5idle", 1'b0, 1'b0, 1'b1);
    cmp("s5.hs", 32'(hs_cnt), 32'd0);

    // Random traffic against the position model.
    for (int i = 0; i < 600; i++)
      step("rnd", $urandom_range(0, 9) < 3,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
